// File: rtl/cv_bus_drive_seq.sv
// cv_bus_drive_seq
//
// Stimulus sequencer for the cv_bus_term array. Test vectors arrive on a
// valid/ready stream and are buffered in a small FIFO. Each vector is driven
// onto the array's in0/in1 buses for a programmable dwell time. The response
// bus `out` is then sampled, and the vector plus its response are returned on
// a second valid/ready stream.
//
// Handshake semantics (both streams): a transfer happens on a rising clk edge
// where valid && ready are both high. A source holds valid and its data stable
// until that transfer. Here s_ready depends only on FIFO occupancy, and
// r_valid/r_data come straight from flops.
//
// Parameters:
//   DEPTH    FIFO entries (power of 2, >= 2)
//   DWELL_W  width of the dwell counter
//
// Ports:
//   clk      sole clock, rising edge
//   rst_n    asynchronous active-low reset
//   dwell    cycles to hold each vector before sampling; latched at pop,
//            0 is treated as 1
//   s_valid  stimulus word valid
//   s_ready  stimulus word can be accepted (FIFO not full)
//   s_data   stimulus word {in1[1:0], in0[1:0]}
//   in0      drives the array's in0 bus
//   in1      drives the array's in1 bus
//   out      array response bus
//   r_valid  result valid
//   r_ready  result accepted
//   r_data   result word {in1, in0, out_sampled}
//   busy     FSM not idle or FIFO non-empty

module cv_bus_drive_seq #(
    parameter int DEPTH   = 4,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [3:0]         s_data,
    output logic [1:0]         in0,
    output logic [1:0]         in1,
    input  logic [1:0]         out,
    output logic               r_valid,
    input  logic               r_ready,
    output logic [5:0]         r_data,
    output logic               busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // FIFO storage and bookkeeping
    logic [3:0]       mem_q [DEPTH];
    logic [3:0]       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Sequencer datapath
    logic [1:0]         in0_q, in0_d;
    logic [1:0]         in1_q, in1_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               r_valid_q, r_valid_d;
    logic [5:0]         r_data_q, r_data_d;

    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic [3:0]         head;
    logic [DWELL_W-1:0] dwell_eff;

    // Full is judged from the count, so a pop in the same cycle as a full
    // FIFO does not let a push through until the following cycle.
    assign fifo_empty = (count_q == '0);
    assign s_ready    = (count_q != FULL_CNT);
    assign push       = s_valid && s_ready;
    assign head       = mem_q[rd_ptr_q];
    assign dwell_eff  = (dwell == '0) ? DWELL_W'(1) : dwell;

    // ------------------------------------------------------------------
    // Sequencer FSM: next state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        in0_d     = in0_q;
        in1_d     = in1_q;
        cnt_d     = cnt_q;
        r_valid_d = r_valid_q;
        r_data_d  = r_data_q;
        pop       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    in1_d   = head[3:2];
                    in0_d   = head[1:0];
                    cnt_d   = dwell_eff;
                    state_d = ST_APPLY;
                end
            end

            ST_APPLY: begin
                // cnt counts the remaining cycles the vector is held; the
                // response is captured on the edge that ends the last one.
                if (cnt_q > DWELL_W'(1)) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else begin
                    r_data_d  = {in1_q, in0_q, out};
                    r_valid_d = 1'b1;
                    state_d   = ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (r_ready) begin
                    r_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        // Chain straight into the next vector on the
                        // handshake edge to get one vector per D+1 cycles.
                        pop     = 1'b1;
                        in1_d   = head[3:2];
                        in0_d   = head[1:0];
                        cnt_d   = dwell_eff;
                        state_d = ST_APPLY;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO next state
    // ------------------------------------------------------------------
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            mem_d[wr_ptr_q] = s_data;
            // DEPTH is a power of 2, so the pointer wraps by overflow.
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            in0_q     <= 2'b00;
            in1_q     <= 2'b00;
            cnt_q     <= '0;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            in0_q     <= in0_d;
            in1_q     <= in1_d;
            cnt_q     <= cnt_d;
            r_valid_q <= r_valid_d;
            r_data_q  <= r_data_d;
            mem_q     <= mem_d;
        end
    end

    assign in0     = in0_q;
    assign in1     = in1_q;
    assign r_valid = r_valid_q;
    assign r_data  = r_data_q;
    assign busy    = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: doc/cv_bus_drive_seq.md
# cv_bus_drive_seq

Stimulus sequencer that sits directly upstream of the `cv_bus_term` array: it drives the array's 2-bit `in0`/`in1` input buses and captures the resulting 2-bit `out` bus. Test vectors enter through a valid/ready stream and are buffered in a small FIFO. Each vector is applied for a programmable dwell time, then `out` is sampled. The applied vector and the sampled response are returned through a second valid/ready stream.

## Interface
- `DEPTH`, default 4: number of FIFO entries; must be a power of 2 and ≥2.
- `DWELL_W`, default 8: width of the dwell counter.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `dwell`  in  DWELL_W  cycles to hold each vector before sampling. Latched at pop; 0 is treated as 1.
- `s_valid`  in  1  stimulus word valid.
- `s_ready`  out  1  stimulus word accepted; equals !full.
- `s_data`  in  4  stimulus word, {in1[1:0], in0[1:0]}.
- `in0`  out  2  drives the array's `in0` bus.
- `in1`  out  2  drives the array's `in1` bus.
- `out`  in  2  array response bus.
- `r_valid`  out  1  result valid.
- `r_ready`  in  1  result accepted.
- `r_data`  out  6  result word, {in1, in0, out_sampled}.
- `busy`  out  1  high when state != IDLE or the FIFO is non-empty.

## Operation
- **FIFO**
  - DEPTH entries of 4 bits, with wrapping read/write pointers and an occupancy count 0..DEPTH.
  - A push occurs on s_valid && s_ready.
  - When full, s_ready=0; a pop in the same cycle does not re-open it.
- **FSM states:** IDLE, APPLY, HOLD.
- **IDLE**
  - If the FIFO is non-empty: pop, register in0/in1 from the entry, set cnt = max(dwell,1), go to APPLY.
  - Otherwise hold in0/in1 at their last values.
- **APPLY**
  - If cnt > 1: cnt <= cnt-1.
  - If cnt == 1: r_data <= {in1, in0, out}, r_valid <= 1, go to HOLD.
- **HOLD**
  - r_valid=1 and r_data stay stable until r_valid && r_ready.
  - On handshake: r_valid <= 0.
  - If the FIFO is non-empty, pop the next entry in the same edge, load in0/in1 and cnt, go to APPLY.
  - Otherwise go to IDLE.
- in0/in1 change only on a pop edge.
- `out` is sampled only on the APPLY cnt==1 edge.
- Changes to `dwell` during APPLY have no effect on the current vector.
- Reset (async, any state):
  - FIFO emptied, pointers and count set to 0.
  - state = IDLE; in0 = in1 = 2'b00; r_valid = 0; r_data = 0; cnt = 0.
  - s_ready = 1 and busy = 0 once reset completes.
  - The in-flight vector is discarded.

## Timing
- Word pushed at edge E0 is popped at E0+1 at the earliest (FIFO has no bypass).
- A vector popped at edge P is stable on in0/in1 for exactly D = max(dwell,1) cycles; `out` is sampled at edge P+D and r_valid rises at P+D.
- Minimum push-to-r_valid latency is 1+D cycles.
- If r_ready is high when r_valid rises:
  - The handshake occurs at edge P+D+1, which also pops the next vector.
  - Steady-state throughput is one vector per D+1 cycles.
- With r_ready held low:
  - The FSM parks in HOLD.
  - The FIFO absorbs DEPTH more words, then s_ready drops.
- Wrap-around: pointers wrap modulo DEPTH. Full is count==DEPTH and empty is count==0; pointer equality alone is not used.

## Test plan
- **Reset:** assert rst_n=0 mid-stream, release → s_ready=1, r_valid=0, r_data=0, in0=in1=0, busy=0 at the first edge after release.
- **Single vector:** dwell=3, push s_data=4'b1001 at E0, bench drives out=2'b10 → in1=2'b10, in0=2'b01 from E1; r_valid rises at E4 with r_data=6'b100110; busy falls after the handshake.
- **Back-to-back:** dwell=2, r_ready=1, push 3 words at E0, E1, E2 → r_valid is captured at E3, E6, E9; in0/in1 update at E1, E4, E7.
- **Full/backpressure:**
  - Setup: DEPTH=4, dwell=1, r_ready=0, s_valid held high with 6 distinct words.
  - Required: word 0 reaches HOLD; words 1–4 fill the FIFO; s_ready=0 and word 5 stalls.
  - On release of r_ready, all 6 results appear in push order with no loss or duplication.
- **dwell=0:** push a word with dwell=0 → behaves identically to dwell=1 (r_valid at pop+1).
- **Reset mid-APPLY:** dwell=10, assert rst_n at pop+4 → in0=in1=0 immediately, no r_valid ever for that vector, FIFO empty.
